heartbeat_pwm_gen: RTL

Heartbeat transmitter for the dual-core switch: generates the 1 kHz, 50 % duty PWM heartbeat that the peer board's pulse detector checks for frequency (±50 clk) and duty (±50 clk). Sits at the core-health output pin. Emits only whole, glitch-free periods while enabled. Optionally stops emitting when the local core stops kicking a watchdog, so the peer sees heartbeat loss.

---
 rtl/heartbeat_pwm_gen_pkg.sv | 18 +
 rtl/heartbeat_pwm_gen_hb_wdog.sv | 60 ++++++
 rtl/heartbeat_pwm_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/heartbeat_pwm_gen_pkg.sv
// Shared definitions for the heartbeat PWM transmitter: oscillator period in
// clocks (`OSC, also used by the UART and the peer pulse detector), FSM state
// encodings and the default watchdog timeout.
`ifndef OSC
`define OSC 14746
`endif

package heartbeat_pwm_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } hb_state_e;

  localparam int KICK_TIMEOUT_DEFAULT = 100;

endpackage

// File: rtl/heartbeat_pwm_gen_hb_wdog.sv
// Heartbeat watchdog: counts completed heartbeat periods since the last kick
// and flags expiry after KICK_TIMEOUT of them. Only built when
// HEARTBEAT_WDOG_EN is defined.
//
// expiring is the combinational "this period end reaches the timeout" term so
// the FSM can refuse to start another period on the very edge the flag rises.
// A kick in the same clock overrides it.
`ifdef HEARTBEAT_WDOG_EN
module hb_wdog
  import heartbeat_pwm_gen_pkg::*;
#(
  parameter int KICK_TIMEOUT = KICK_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic period_done,
  input  logic kick,
  output logic expired,
  output logic expiring
);

  localparam logic [15:0] TIMEOUT      = 16'(KICK_TIMEOUT);
  localparam logic [15:0] TIMEOUT_LAST = 16'(KICK_TIMEOUT - 1);

  logic [15:0] count_q, count_d;
  logic        expired_q, expired_d;

  assign expiring = period_done && !kick && (count_q >= TIMEOUT_LAST);
  assign expired  = expired_q;

  // Period count: kick clears, completed periods advance (saturating at timeout).
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (kick) begin
      count_d   = 16'd0;
      expired_d = 1'b0;
    end else if (period_done) begin
      if (count_q < TIMEOUT) begin
        count_d = count_q + 16'd1;
      end
      if (expiring) begin
        expired_d = 1'b1;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 16'd0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

endmodule
`endif

// File: rtl/heartbeat_pwm_gen.sv
// Heartbeat PWM transmitter: whole, glitch-free periods of PERIOD clocks with
// HIGH_CYCLES high, back-to-back while en is high. Optional watchdog
// (HEARTBEAT_WDOG_EN) halts output when the core stops kicking.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | output low, waiting for en (and no watchdog expiry)
// ST_HIGH | high phase, cnt 0 .. HIGH_CYCLES-1
// ST_LOW  | low phase, cnt HIGH_CYCLES .. PERIOD-1
module heartbeat_pwm_gen
  import heartbeat_pwm_gen_pkg::*;
#(
  parameter int PERIOD       = `OSC,
  parameter int HIGH_CYCLES  = PERIOD / 2,
  parameter int KICK_TIMEOUT = KICK_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic pwm,
  output logic active,
  output logic period_tick,
  output logic wdog_expired
);

  if (PERIOD < 4 || PERIOD > 65535) begin : g_bad_period
    $error("heartbeat_pwm_gen: PERIOD out of range");
  end
  if (HIGH_CYCLES < 1 || HIGH_CYCLES >= PERIOD) begin : g_bad_high
    $error("heartbeat_pwm_gen: HIGH_CYCLES out of range");
  end
  if (KICK_TIMEOUT < 1 || KICK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("heartbeat_pwm_gen: KICK_TIMEOUT out of range");
  end

  localparam logic [15:0] HIGH_LAST   = 16'(HIGH_CYCLES - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);

  hb_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pwm_q, pwm_d;
  logic        active_q, active_d;
  logic        tick_q, tick_d;

  logic period_done;
  logic wdog_block;
  logic may_start;

  assign period_done = (state_q == ST_LOW) && (cnt_q == PERIOD_LAST);

`ifdef HEARTBEAT_WDOG_EN
  logic wdog_expired_w;
  logic wdog_expiring_w;

  hb_wdog #(
    .KICK_TIMEOUT(KICK_TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_done(period_done),
    .kick       (kick),
    .expired    (wdog_expired_w),
    .expiring   (wdog_expiring_w)
  );

  assign wdog_block   = wdog_expired_w | wdog_expiring_w;
  assign wdog_expired = wdog_expired_w;
`else
  // Without the watchdog kick has no effect on the output.
  assign wdog_block   = 1'b0;
  assign wdog_expired = 1'b0 & kick;
`endif

  assign may_start = en && !wdog_block;

  // Next state, phase counter and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (may_start) begin
          state_d = ST_HIGH;
          cnt_d   = 16'd0;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HIGH_LAST) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (period_done) begin
          state_d = may_start ? ST_HIGH : ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    pwm_d    = (state_d == ST_HIGH);
    active_d = (state_d != ST_IDLE);
    tick_d   = (state_d == ST_HIGH) && (cnt_d == 16'd0);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      pwm_q    <= 1'b0;
      active_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign pwm         = pwm_q;
  assign active      = active_q;
  assign period_tick = tick_q;

endmodule
